// File: rtl/mips_defs.sv
// mips_defs: shared MIPS CP0 definitions.
//   CP0 register numbers, ExcCode values, SR/Cause bit positions,
//   exception handler address, and helpers that pack SR/Cause words.
package mips_defs;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_BD_BIT = 31;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_LO = 2;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    // SR: IM in 15:10, EXL in 1, IE in 0, everything else reads 0.
    function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl,
                                            input logic ie);
        sr_word = {16'b0, im, 8'b0, exl, ie};
    endfunction

    // Cause: BD in 31, IP in 15:10, ExcCode in 6:2.
    function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc);
        cause_word = {bd, 15'b0, ip, 3'b0, exc, 2'b0};
    endfunction

endpackage

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS coprocessor-0 exception/interrupt controller beside the M stage.
//   Ports: clk, reset (async, active-high); en/addr/wdata mtc0 write, rdata mfc0 read;
//   vpc/bd_in/exc_code_in describe the M instruction; hw_int external interrupt levels;
//   eret return strobe; req redirects fetch to the handler; epc_out return address.
//   Optional macro CP0_BD_EN: capture Cause.BD and back EPC up to the branch for
//   delay-slot victims; undefined -> bd_in ignored, BD reads 0, EPC = vpc.
module cp0_ctrl
    import mips_defs::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h0000_0913
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic        int_req, exc_req;
    logic        wr_sr, wr_epc;
    logic [31:0] epc_take;

    assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
    assign exc_req = (exc_code_in != EXC_INT) & ~exl_q;
    assign req     = int_req | exc_req;

    // A taken exception flushes the mtc0, so its write is dropped.
    assign wr_sr  = en & ~req & (addr == CP0_SR);
    assign wr_epc = en & ~req & (addr == CP0_EPC);

`ifdef CP0_BD_EN
    assign epc_take = bd_in ? vpc - 32'd4 : vpc;
`else
    logic unused_bd;
    assign unused_bd = bd_in;
    assign epc_take  = vpc;
`endif

    always_comb begin
        im_d  = wr_sr ? wdata[SR_IM_LO +: 6] : im_q;
        ie_d  = wr_sr ? wdata[SR_IE_BIT] : ie_q;
        exl_d = wr_sr ? wdata[SR_EXL_BIT] : exl_q;
        epc_d = wr_epc ? wdata : epc_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        ip_d  = hw_int;
        if (req) begin
            exl_d = 1'b1;
            exc_d = int_req ? EXC_INT : exc_code_in;
            epc_d = epc_take;
`ifdef CP0_BD_EN
            bd_d  = bd_in;
`endif
        end else if (eret) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        rdata = (addr == CP0_SR)    ? sr_word(im_q, exl_q, ie_q) :
                (addr == CP0_CAUSE) ? cause_word(bd_q, ip_q, exc_q) :
                (addr == CP0_EPC)   ? epc_q :
                (addr == CP0_PRID)  ? PRID_VAL : 32'h0;
    end

    // Forward an in-flight EPC write so an immediately following eret needs no stall.
    assign epc_out = (en && addr == CP0_EPC) ? wdata : epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed self-checking bench for cp0_ctrl.
module tb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [31:0] vpc = 32'h0;
    logic        bd_in = 1'b0;
    logic [4:0]  exc_code_in = 5'd0;
    logic [5:0]  hw_int = 6'd0;
    logic        eret = 1'b0;
    logic        req;
    logic [31:0] epc_out;

    int compared = 0;
    int mismatched = 0;

    cp0_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .addr(addr), .wdata(wdata), .rdata(rdata),
        .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
        .eret(eret), .req(req), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; eret = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; bd_in = 1'b0;
        addr = 5'd0; wdata = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] exp [4];
        exp = '{32'h0, 32'h0, 32'h0, 32'h0000_0913};
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        compared++;
        if (req !== 1'b0) begin
            mismatched++; $display("FAIL reset_req got %b want 0", req);
        end
        compared++;
        if (epc_out !== 32'h0) begin
            mismatched++; $display("FAIL reset_epc_out got %h want 0", epc_out);
        end
        for (int i = 0; i < 4; i++) begin
            addr = 5'(12 + i);
            #1;
            compared++;
            if (rdata !== exp[i]) begin
                mismatched++;
                $display("FAIL reset_rdata%0d got %h want %h", 12 + i, rdata, exp[i]);
            end
        end
    endtask

    task automatic test_registers();
        addr = 5'd3;
        #1;
        compared++;
        if (rdata !== 32'h0) begin
            mismatched++; $display("FAIL unmapped_read got %h want 0", rdata);
        end
        en = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
        tick();
        en = 1'b0;
        #1;
        compared++;
        if (rdata !== 32'h0) begin
            mismatched++; $display("FAIL cause_readonly got %h want 0", rdata);
        end
        en = 1'b1; addr = 5'd12; wdata = 32'hFFFF_FFFF;
        tick();
        en = 1'b0;
        #1;
        compared++;
        if (rdata !== 32'h0000_FC03) begin
            mismatched++; $display("FAIL sr_mask got %h want 0000fc03", rdata);
        end
        en = 1'b1; wdata = 32'h0000_0401;
        tick();
        en = 1'b0;
        #1;
        compared++;
        if (rdata !== 32'h0000_0401) begin
            mismatched++; $display("FAIL sr_write got %h want 00000401", rdata);
        end
    endtask

    task automatic test_interrupt();
        hw_int = 6'b000001; vpc = 32'h0000_1000;
        #1;
        compared++;
        if (req !== 1'b1) begin
            mismatched++; $display("FAIL int_req got %b want 1", req);
        end
        tick();
        hw_int = 6'd0; addr = 5'd12;
        #1;
        compared++;
        if (rdata !== 32'h0000_0403) begin
            mismatched++; $display("FAIL int_sr got %h want 00000403", rdata);
        end
        addr = 5'd13;
        #1;
        compared++;
        if (rdata !== 32'h0000_0400) begin
            mismatched++; $display("FAIL int_cause got %h want 00000400", rdata);
        end
        addr = 5'd14;
        #1;
        compared++;
        if (rdata !== 32'h0000_1000) begin
            mismatched++; $display("FAIL int_epc got %h want 00001000", rdata);
        end
    endtask

    task automatic test_exl_mask();
        hw_int = 6'b000001; exc_code_in = 5'd10; vpc = 32'h0000_2222;
        #1;
        compared++;
        if (req !== 1'b0) begin
            mismatched++; $display("FAIL exl_mask_req got %b want 0", req);
        end
        tick();
        idle();
        addr = 5'd14;
        #1;
        compared++;
        if (rdata !== 32'h0000_1000) begin
            mismatched++; $display("FAIL exl_mask_epc got %h want 00001000", rdata);
        end
        addr = 5'd13;
        #1;
        compared++;
        if (rdata !== 32'h0000_0400) begin
            mismatched++; $display("FAIL exl_mask_cause got %h want 00000400", rdata);
        end
    endtask

    task automatic test_eret_forward();
        en = 1'b1; addr = 5'd14; wdata = 32'h0000_3100; eret = 1'b1;
        #1;
        compared++;
        if (epc_out !== 32'h0000_3100) begin
            mismatched++; $display("FAIL eret_fwd_epc_out got %h want 00003100", epc_out);
        end
        tick();
        idle();
        addr = 5'd12;
        #1;
        compared++;
        if (rdata !== 32'h0000_0401) begin
            mismatched++; $display("FAIL eret_sr got %h want 00000401", rdata);
        end
    endtask

    task automatic test_refire();
        hw_int = 6'b000001; vpc = 32'h0000_1100;
        tick();
        eret = 1'b1;
        #1;
        compared++;
        if (req !== 1'b0) begin
            mismatched++; $display("FAIL refire_masked got %b want 0", req);
        end
        tick();
        eret = 1'b0;
        #1;
        compared++;
        if (req !== 1'b1) begin
            mismatched++; $display("FAIL refire_after_eret got %b want 1", req);
        end
        tick();
        hw_int = 6'd0; eret = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_exception();
        exc_code_in = 5'd12; vpc = 32'h0000_3010; bd_in = 1'b1;
        #1;
        compared++;
        if (req !== 1'b1) begin
            mismatched++; $display("FAIL exc_req got %b want 1", req);
        end
        tick();
        idle();
        addr = 5'd14;
        #1;
`ifdef CP0_BD_EN
        compared++;
        if (rdata !== 32'h0000_300C) begin
            mismatched++; $display("FAIL exc_epc got %h want 0000300c", rdata);
        end
        addr = 5'd13;
        #1;
        compared++;
        if (rdata !== 32'h8000_0030) begin
            mismatched++; $display("FAIL exc_cause got %h want 80000030", rdata);
        end
`else
        compared++;
        if (rdata !== 32'h0000_3010) begin
            mismatched++; $display("FAIL exc_epc got %h want 00003010", rdata);
        end
        addr = 5'd13;
        #1;
        compared++;
        if (rdata !== 32'h0000_0030) begin
            mismatched++; $display("FAIL exc_cause got %h want 00000030", rdata);
        end
`endif
        eret = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_priority();
        hw_int = 6'b000001; exc_code_in = 5'd4; vpc = 32'h0000_2000;
        en = 1'b1; addr = 5'd12; wdata = 32'h0;
        #1;
        compared++;
        if (req !== 1'b1) begin
            mismatched++; $display("FAIL prio_req got %b want 1", req);
        end
        tick();
        idle();
        addr = 5'd12;
        #1;
        compared++;
        if (rdata !== 32'h0000_0403) begin
            mismatched++; $display("FAIL prio_sr_suppressed got %h want 00000403", rdata);
        end
        addr = 5'd13;
        #1;
        compared++;
        if (rdata !== 32'h0000_0400) begin
            mismatched++; $display("FAIL prio_cause got %h want 00000400", rdata);
        end
        addr = 5'd14;
        #1;
        compared++;
        if (rdata !== 32'h0000_2000) begin
            mismatched++; $display("FAIL prio_epc got %h want 00002000", rdata);
        end
    endtask

    task automatic test_async_reset();
        hw_int = 6'b000001;
        reset = 1'b1;
        #1;
        compared++;
        if (req !== 1'b0) begin
            mismatched++; $display("FAIL areset_req got %b want 0", req);
        end
        for (int i = 12; i < 15; i++) begin
            addr = 5'(i);
            #1;
            compared++;
            if (rdata !== 32'h0) begin
                mismatched++; $display("FAIL areset_rdata%0d got %h want 0", i, rdata);
            end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_registers();
        test_interrupt();
        test_exl_mask();
        test_eret_forward();
        test_refire();
        test_exception();
        test_priority();
        test_async_reset();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Coprocessor-0 exception/interrupt controller for the pipelined MIPS core. Sits beside the M stage; decides each cycle whether the instruction in M is taken by an exception or external interrupt, raises `req` to redirect fetch to the handler at 0x0000_4180 and flush the pipe, and captures SR/Cause/EPC state. Supplies `epc_out` so fetch can resume on `eret`, and serves `mtc0`/`mfc0` accesses.

## Interface
- `PRID_VAL`, 32'h0000_0913, constant returned for register 15 (PRId)
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `en`  in  1  mtc0 write strobe from M stage
- `addr`  in  5  CP0 register number for read and write
- `wdata`  in  32  mtc0 write data
- `rdata`  out  32  mfc0 read data, combinational from `addr`
- `vpc`  in  32  PC of the instruction currently in M
- `bd_in`  in  1  M instruction sits in a branch-delay slot
- `exc_code_in`  in  5  synchronous exception code of M instruction, 0 = none
- `hw_int`  in  6  external interrupt lines, level-sensitive
- `eret`  in  1  eret in M stage
- `req`  out  1  take exception/interrupt this cycle (combinational)
- `epc_out`  out  32  return address for eret, write-forwarded

## Operation
- SR (12): IM = bits 15:10, EXL = bit 1, IE = bit 0; all other bits read 0, writes to them ignored.
- Cause (13): BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2; read-only to mtc0.
- EPC (14): full 32 bits writable. PRId (15): `PRID_VAL`. Any other `addr` reads 0.
- `int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL`; `exc_req = (exc_code_in != 0) & ~SR.EXL`; `req = int_req | exc_req`.
- Interrupt has priority over exception: on `req`, ExcCode <= `int_req` ? 0 : `exc_code_in`.
- On `req`: EXL <= 1; EPC <= `bd_in` ? `vpc`-4 : `vpc`; BD <= `bd_in`.
- On `eret` (without `req`): EXL <= 0. IE unchanged.
- Cause.IP <= `hw_int` every cycle, independent of masks.
- `mtc0` to 12/14 takes effect when `en` and not `req`; `req` suppresses the write (instruction flushed).
- Priority per cycle: reset > req > eret > mtc0.
- `epc_out` = (`en` & `addr`==14) ? `wdata` : EPC, so mtc0 EPC immediately followed by eret needs no stall.

## Timing
- Reset values: SR, Cause, EPC all 0; `req` 0 (IE clear); `rdata` 0 for addr 12/13/14; `epc_out` 0.
- `req` and `rdata` valid in the same cycle as inputs; register updates visible on next rising edge.
- After `req`, EXL=1 masks both sources from the next cycle until `eret` retires.
- Reset asserted mid-handler: EXL cleared immediately, pending `req` dropped.
- Simultaneous `req` and `eret` (only possible with EXL=0): `req` wins, EXL set.
- `hw_int` held high through handler re-fires the cycle after eret clears EXL if still enabled.

## Configuration
- `CP0_BD_EN`: defined -> BD captured and EPC = `vpc`-4 for delay-slot victims.
- Undefined -> `bd_in` ignored, Cause.BD reads 0, EPC = `vpc` always.

## Structure
- Shared package `mips_defs`: CP0 register numbers (12–15), ExcCode constants (Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12), SR/Cause bit positions, handler address 32'h0000_4180.
- Single module; no sub-module is natural.

## Test plan
- Reset, mtc0 SR=32'h0000_0401, hw_int=6'b000001 -> `req`=1 same cycle, next cycle Cause.ExcCode=0, EXL=1, EPC=`vpc`.
- EXL=0, exc_code_in=12, vpc=32'h0000_3010, bd_in=1 -> `req`=1; EPC=32'h0000_300C, BD=1 (with `CP0_BD_EN`); EPC=32'h0000_3010, BD=0 without.
- EXL=1, exc_code_in=10 and hw_int enabled -> `req`=0, no register change.
- mtc0 EPC=32'h0000_3100 with eret same cycle -> `epc_out`=32'h0000_3100 that cycle; EXL=0 next.
- Interrupt and exc_code_in=4 together -> ExcCode=0; en=1 write to SR suppressed.
- Reset pulse mid-handler (EXL=1) asynchronously -> SR/Cause/EPC read 0 before next edge.
